mips_fetch_stage: RTL and testbench
===================================

Name: mips_fetch_stage

Overview:
- Parametrised instruction-fetch stage for the MIPS pipeline.
- Replaces the discrete PC register, nPC register and PC adder, and owns the IF/ID register.
- Uses MIPS delay-slot sequencing: PC takes nPC; nPC takes PC+4 or a redirect target.
- Adds stall, pending-redirect capture, IF/ID flush and misalignment fault detection, driving a combinational byte-addressed big-endian instruction ROM.

Parameters:
- ADDR_W, 32, width of PC/nPC and of target buses.
- RESET_PC, 0, PC value after reset; nPC resets to RESET_PC+4.
- IMEM_AW, 9, ROM byte-address width (512-byte ROM); imem_addr = pc[IMEM_AW-1:0].
- NOP_WORD, 32'h00000000, word loaded into IF/ID on flush and reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC, nPC and IF/ID this cycle.
- redirect  in  1  branch/jump resolved taken; load redirect_target into nPC.
- redirect_target  in  ADDR_W  branch/jump target address.
- flush  in  1  squash IF/ID contents.
- imem_data  in  32  ROM word at imem_addr (combinational).
- imem_addr  out  IMEM_AW  ROM byte address.
- pc  out  ADDR_W  current fetch PC.
- npc  out  ADDR_W  next PC.
- ifid_instr  out  32  IF/ID instruction.
- ifid_pc  out  ADDR_W  PC of ifid_instr.
- ifid_valid  out  1  IF/ID holds a live instruction.
- redirect_pending  out  1  a redirect is held awaiting stall release.
- fetch_fault  out  1  sticky misaligned-PC flag.

Behaviour:
- Reset (reset=0, asynchronous, regardless of clk):
  - pc=RESET_PC, npc=RESET_PC+4.
  - ifid_instr=NOP_WORD, ifid_pc=0, ifid_valid=0.
  - redirect_pending=0, pend_target=0, fetch_fault=0.
- Reset release: the first rising edge after release performs a normal advance.
- Datapath:
  - imem_addr = pc[IMEM_AW-1:0], combinational. Addresses wrap modulo 2^IMEM_AW.
  - seq = npc + 4, computed modulo 2^ADDR_W; wrap from all-ones-minus-3 to 0 is legal.
- Two-state FSM, RUN and HOLD:
  - redirect_pending = (state==HOLD).
  - pend_target is an internal register.
- RUN, stall=0 (advance):
  - pc<=npc.
  - npc<=redirect ? redirect_target : seq.
  - IF/ID <= {imem_data, pc, valid=1}.
  - Stay in RUN.
- RUN, stall=1:
  - pc, npc and IF/ID hold.
  - If redirect=1: pend_target<=redirect_target and go to HOLD.
- HOLD, stall=1:
  - Hold pc, npc and IF/ID.
  - A new redirect overwrites pend_target (newest wins).
- HOLD, stall=0:
  - pc<=npc.
  - npc<=redirect ? redirect_target : pend_target; a same-cycle redirect beats the pending one.
  - IF/ID loads as in an advance.
  - Go to RUN.
- Delay slot: the instruction at the old npc (delay slot) is always fetched before the target. This stage never squashes the delay slot.
- Flush:
  - Overrides the IF/ID load: IF/ID <= {NOP_WORD, pc, valid=0}.
  - Applies even when stall=1; flush beats stall for IF/ID only.
  - pc, npc and FSM behave as if flush were absent.
- Misalignment:
  - If pc[1:0]!=0 at an advancing edge, IF/ID loads NOP_WORD with valid=0.
  - fetch_fault<=1 and stays set until reset. PC sequencing continues.
- Latency: instruction at PC p appears on ifid_instr one edge after pc==p with stall=0.
- All outputs are registered except imem_addr.

Test Plan:
- Reset then 4 free-running edges, ROM words W0..W3 at 0,4,8,12 -> pc sequence 0,4,8,12,16; ifid_instr W0..W3; ifid_pc 0,4,8,12; ifid_valid=1 from edge 1.
- redirect=1, redirect_target=0x40 while pc=8, npc=12 -> next edge pc=12, npc=0x40; following edge pc=0x40, ifid_instr=word@12 (delay slot), npc=0x44.
- stall=1 for 3 edges with redirect pulsed to 0x80 on the first, then stall=0 -> redirect_pending=1 during stall; pc/npc/IF/ID frozen; on release npc=0x80 and pending clears.
- In HOLD, redirect 0x80 then 0xA0 during stall, and redirect 0xC0 at release -> npc=0xC0; without the release redirect -> npc=0xA0.
- flush=1 with stall=1 at pc=0x10 -> ifid_valid=0, ifid_instr=0, pc stays 0x10; redirect to 0x22 -> when pc=0x22 advances, fetch_fault=1, ifid_valid=0, pc continues 0x26; reset clears fault.
- Assert reset (to 0) mid-cycle while clk high -> all outputs reach reset values immediately, before the next edge; RESET_PC=0x100 variant gives pc=0x100, npc=0x104.

Source files
------------

// File: rtl/mips_fetch_stage.sv
// mips_fetch_stage: MIPS IF stage with PC/nPC delay-slot sequencing, stall, held redirect, IF/ID flush and misalignment fault
// Ports: clk, reset (async active-low); stall freezes PC/nPC/IF-ID; redirect/redirect_target load nPC;
// flush squashes IF/ID; imem_data/imem_addr talk to a combinational ROM; pc/npc current and next fetch PC;
// ifid_instr/ifid_pc/ifid_valid form the IF/ID register; redirect_pending shows a held redirect; fetch_fault is sticky.
module mips_fetch_stage #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int IMEM_AW = 9,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  input  logic redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic flush,
  input  logic [31:0] imem_data,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc,
  output logic [31:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic ifid_valid,
  output logic redirect_pending,
  output logic fetch_fault
);
  typedef enum logic {RUN, HOLD} state_t;
  state_t state;
  logic [ADDR_W-1:0] pend_target, seq;
  logic misal;
  assign imem_addr = pc[IMEM_AW-1:0];
  assign seq = npc + ADDR_W'(4);
  assign misal = |pc[1:0];
  assign redirect_pending = state == HOLD;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      pc <= RESET_PC;
      npc <= RESET_PC + ADDR_W'(4);
      pend_target <= '0;
      ifid_instr <= NOP_WORD;
      ifid_pc <= '0;
      ifid_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      if (!stall) begin
        pc <= npc;
        // a redirect arriving on the release cycle is newer than the held one
        npc <= redirect ? redirect_target : (state == HOLD ? pend_target : seq);
        state <= RUN;
        ifid_instr <= misal ? NOP_WORD : imem_data;
        ifid_pc <= pc;
        ifid_valid <= !misal;
        if (misal) fetch_fault <= 1'b1;
      end else if (redirect) begin
        pend_target <= redirect_target;
        state <= HOLD;
      end
      // flush wins over both stall and a normal load, but only for IF/ID
      if (flush) begin
        ifid_instr <= NOP_WORD;
        ifid_pc <= pc;
        ifid_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mips_fetch_stage.sv
// tb_mips_fetch_stage: randomized and directed check of mips_fetch_stage against a behavioural model
module tb_mips_fetch_stage;
  logic clk = 0, reset = 0, stall = 0, redirect = 0, flush = 0;
  logic [31:0] redirect_target = 0, imem_data;
  logic [8:0] imem_addr, imem_addr2;
  logic [31:0] pc, npc, ifid_instr, ifid_pc, pc2, npc2, ifid_instr2, ifid_pc2;
  logic ifid_valid, redirect_pending, fetch_fault, ifid_valid2, redirect_pending2, fetch_fault2;
  logic [31:0] rom [128];
  int n_tests = 0, n_fail = 0;
  logic [31:0] m_pc, m_npc, m_pt, m_ii, m_ipc;
  logic m_pend, m_iv, m_ff;

  always #5 clk = ~clk;
  assign imem_data = rom[imem_addr[8:2]];

  mips_fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
    .flush(flush), .imem_data(imem_data), .imem_addr(imem_addr), .pc(pc), .npc(npc),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
    .redirect_pending(redirect_pending), .fetch_fault(fetch_fault));

  mips_fetch_stage #(.RESET_PC(32'h100)) dut2 (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
    .flush(flush), .imem_data(32'h0), .imem_addr(imem_addr2), .pc(pc2), .npc(npc2),
    .ifid_instr(ifid_instr2), .ifid_pc(ifid_pc2), .ifid_valid(ifid_valid2),
    .redirect_pending(redirect_pending2), .fetch_fault(fetch_fault2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all();
    chk("pc", pc, m_pc);
    chk("npc", npc, m_npc);
    chk("imem_addr", imem_addr, m_pc[8:0]);
    chk("ifid_instr", ifid_instr, m_ii);
    chk("ifid_pc", ifid_pc, m_ipc);
    chk("ifid_valid", ifid_valid, m_iv);
    chk("pending", redirect_pending, m_pend);
    chk("fault", fetch_fault, m_ff);
  endtask

  // one clock: drive inputs, predict the registered state from the rules, compare after the edge
  task automatic step(input logic st, input logic rd, input logic fl, input logic [31:0] tg);
    logic [31:0] old_pc;
    stall = st; redirect = rd; flush = fl; redirect_target = tg;
    old_pc = m_pc;
    if (!st) begin
      m_ipc = m_pc;
      if (m_pc % 4 != 0) begin m_ii = 0; m_iv = 0; m_ff = 1; end
      else begin m_ii = rom[(m_pc % 512) / 4]; m_iv = 1; end
      m_pc = m_npc;
      m_npc = rd ? tg : (m_pend ? m_pt : m_npc + 4);
      m_pend = 0;
    end else if (rd) begin
      m_pend = 1; m_pt = tg;
    end
    if (fl) begin m_ii = 0; m_ipc = old_pc; m_iv = 0; end
    @(posedge clk); #1;
    chk_all();
  endtask

  // reset asserted while clk is high must take effect without an edge
  task automatic do_reset();
    @(posedge clk); #2;
    reset = 0; stall = 0; redirect = 0; flush = 0;
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_npc", npc, 4);
    chk("rst_valid", ifid_valid, 0);
    chk("rst_instr", ifid_instr, 0);
    chk("rst_pend", redirect_pending, 0);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_pc2", pc2, 32'h100);
    chk("rst_npc2", npc2, 32'h104);
    @(posedge clk); #1;
    reset = 1;
    m_pc = 0; m_npc = 4; m_pt = 0; m_pend = 0; m_ii = 0; m_ipc = 0; m_iv = 0; m_ff = 0;
    chk_all();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = $urandom;
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk("run_pc", pc, 16);
    chk("run_instr", ifid_instr, rom[3]);
    chk("run_ifid_pc", ifid_pc, 12);

    do_reset();
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(0, 1, 0, 32'h40);
    chk("redir_npc", npc, 32'h40);
    step(0, 0, 0, 0);
    chk("redir_pc", pc, 32'h40);
    chk("delay_slot", ifid_instr, rom[3]);
    chk("redir_npc2", npc, 32'h44);

    step(1, 1, 0, 32'h80);
    chk("hold_pend", redirect_pending, 1);
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("hold_release", npc, 32'h80);
    step(1, 1, 0, 32'h80); step(1, 1, 0, 32'hA0);
    step(0, 1, 0, 32'hC0);
    chk("newest_redirect", npc, 32'hC0);
    step(1, 1, 0, 32'h80); step(1, 1, 0, 32'hA0);
    step(0, 0, 0, 0);
    chk("newest_pending", npc, 32'hA0);

    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(1, 0, 1, 0);
    chk("flush_valid", ifid_valid, 0);
    chk("flush_pc", pc, 32'h10);
    step(0, 1, 0, 32'h22);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("misal_fault", fetch_fault, 1);
    chk("misal_pc", pc, 32'h26);

    step(0, 1, 0, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("wrap_pc", pc, 0);

    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tg;
      tg = $urandom_range(0, 127) * 4;
      if ($urandom_range(0, 19) == 0) tg = tg + 2;
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, $urandom_range(0, 9) == 0, tg);
      if (i == 200) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
